// File: rtl/silly_function_pkg.sv
// silly_function_pkg: shared width default and the per-lane Boolean function.
// The lane function is kept here so any block that needs the truth-table element
// evaluates exactly the same expression.
package silly_function_pkg;

  localparam int DEFAULT_WIDTH = 1;

  // One lane of y = (~b & ~c) | (a & ~b)
  function automatic logic silly_bit(input logic a, input logic b, input logic c);
    return (~b & ~c) | (a & ~b);
  endfunction

endpackage

// File: rtl/silly_function_if.sv
// silly_function_if: operand/result bundle for silly_function.
// The master side drives the operands; the slave side (the function block)
// returns the combinational result, the registered copy and its valid flag.
interface silly_function_if
  import silly_function_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             y_q_valid;

  modport master (
    output a,
    output b,
    output c,
    input  y,
    input  y_q,
    input  y_q_valid
  );

  modport slave (
    input  a,
    input  b,
    input  c,
    output y,
    output y_q,
    output y_q_valid
  );

endinterface

// File: rtl/silly_function_lane.sv
// silly_function_lane: a single 1-bit combinational lane of the function.
// Lanes are fully independent, so the top simply replicates this cell.
module silly_function_lane
  import silly_function_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = silly_bit(a, b, c);

endmodule

// File: rtl/silly_function.sv
// silly_function: WIDTH-lane Boolean function y = ~b & (a | ~c) with a
// zero-latency combinational output and a registered copy plus valid flag.
// The combinational path ignores clk/rst_n entirely, so y stays meaningful
// even while the register stage is held in reset.
module silly_function
  import silly_function_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)(
  input  logic                  clk,
  input  logic                  rst_n,
  silly_function_if.slave       bus
);

  logic [WIDTH-1:0] y_comb;
  logic [WIDTH-1:0] y_reg;
  logic             valid_reg;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    silly_function_lane u_lane (
      .a (bus.a[i]),
      .b (bus.b[i]),
      .c (bus.c[i]),
      .y (y_comb[i])
    );
  end

  // Capture the combinational result each edge; valid rises on the first edge out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_reg     <= '0;
      valid_reg <= 1'b0;
    end else begin
      y_reg     <= y_comb;
      valid_reg <= 1'b1;
    end
  end

  assign bus.y         = y_comb;
  assign bus.y_q       = y_reg;
  assign bus.y_q_valid = valid_reg;

endmodule

// File: tb/tb_silly_function.sv
// tb_silly_function: directed and random checks of silly_function at WIDTH=1
// and WIDTH=8, sharing one clock and reset between the two instances.
module tb_silly_function;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  // Hand-written truth table indexed by {a,b,c}: 000->1 ... 111->0
  logic [7:0] truth;

  silly_function_if #(.WIDTH(1)) bus1 ();
  silly_function_if #(.WIDTH(8)) bus8 ();

  silly_function #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  silly_function #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] abc1,
                               input logic [7:0] a8,
                               input logic [7:0] b8,
                               input logic [7:0] c8);
    bus1.a = abc1[2];
    bus1.b = abc1[1];
    bus1.c = abc1[0];
    bus8.a = a8;
    bus8.b = b8;
    bus8.c = c8;
  endtask

  task automatic checkOutput(input string tag,
                             input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Directed sequence followed by the random regression
  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rc;
    logic [7:0] model;
    logic       prev;

    vectors     = 0;
    miscompares = 0;
    truth       = 8'b0011_0001;

    rst_n = 1'b0;
    applyStimulus(3'b100, 8'h00, 8'h00, 8'h00);

    // Reset held for three edges with abc=100
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_y",        {7'd0, bus1.y},         8'h01);
      checkOutput("rst_yq",       {7'd0, bus1.y_q},       8'h00);
      checkOutput("rst_valid",    {7'd0, bus1.y_q_valid}, 8'h00);
      checkOutput("rst_yq_w8",    bus8.y_q,               8'h00);
      checkOutput("rst_valid_w8", {7'd0, bus8.y_q_valid}, 8'h00);
    end

    rst_n = 1'b1;
    tick();
    checkOutput("rel_yq",       {7'd0, bus1.y_q},       8'h01);
    checkOutput("rel_valid",    {7'd0, bus1.y_q_valid}, 8'h01);
    checkOutput("rel_valid_w8", {7'd0, bus8.y_q_valid}, 8'h01);

    // Exhaustive sweep, each pattern held ten cycles
    prev = 1'b1;
    for (int v = 0; v < 8; v++) begin
      applyStimulus(3'(v), 8'h00, 8'h00, 8'h00);
      #1;
      checkOutput("sweep_y_now",  {7'd0, bus1.y},   {7'd0, truth[v]});
      checkOutput("sweep_yq_old", {7'd0, bus1.y_q}, {7'd0, prev});
      for (int k = 0; k < 10; k++) begin
        tick();
        checkOutput("sweep_y",  {7'd0, bus1.y},   {7'd0, truth[v]});
        checkOutput("sweep_yq", {7'd0, bus1.y_q}, {7'd0, truth[v]});
      end
      prev = truth[v];
    end

    // Reset mid-stream with abc=101
    applyStimulus(3'b101, 8'h00, 8'h00, 8'h00);
    tick();
    checkOutput("mid_pre_yq", {7'd0, bus1.y_q}, 8'h01);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_yq",    {7'd0, bus1.y_q},       8'h00);
    checkOutput("mid_rst_valid", {7'd0, bus1.y_q_valid}, 8'h00);
    checkOutput("mid_rst_y",     {7'd0, bus1.y},         8'h01);
    rst_n = 1'b1;
    tick();
    checkOutput("mid_rel_yq",    {7'd0, bus1.y_q},       8'h01);
    checkOutput("mid_rel_valid", {7'd0, bus1.y_q_valid}, 8'h01);

    // Multi-lane directed vector
    applyStimulus(3'b000, 8'hF0, 8'hCC, 8'hAA);
    #1;
    checkOutput("w8_y", bus8.y, 8'h31);
    tick();
    checkOutput("w8_yq", bus8.y_q, 8'h31);

    // Combinational timing: 000 -> 010 in the middle of a cycle
    tick();
    checkOutput("ct_yq_before", {7'd0, bus1.y_q}, 8'h01);
    #3;
    applyStimulus(3'b010, 8'hF0, 8'hCC, 8'hAA);
    #1;
    checkOutput("ct_y_fell",  {7'd0, bus1.y},   8'h00);
    checkOutput("ct_yq_held", {7'd0, bus1.y_q}, 8'h01);
    tick();
    checkOutput("ct_yq_after", {7'd0, bus1.y_q}, 8'h00);

    // Random regression on the 8-lane instance
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 8'($urandom);
      model = ~rb & (ra | ~rc);
      applyStimulus(3'b000, ra, rb, rc);
      #1;
      checkOutput("rand_y", bus8.y, model);
      tick();
      checkOutput("rand_yq", bus8.y_q, model);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/silly_function.md
Name: silly_function

Overview:
- Bitwise 3-input Boolean function y = (~b & ~c) | (a & ~b), applied per lane across WIDTH lanes.
- Provides a combinational output and a registered copy with a valid flag, so it can feed either combinational logic or clocked pipelines.
- Small leaf block used as a truth-table reference element in exercise and verification flows.

Parameters:
- WIDTH, 1, number of independent bit lanes; each lane computes the function on its own a/b/c bits.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- c  input  WIDTH  operand C, one bit per lane.
- y  output  WIDTH  combinational result, per lane y[i] = (~b[i] & ~c[i]) | (a[i] & ~b[i]).
- y_q  output  WIDTH  registered result: y sampled at the previous rising clk edge.
- y_q_valid  output  1  high once y_q holds a value computed after reset.

Behaviour:
- Per-lane truth table (a b c -> y): 000->1, 001->0, 010->0, 011->0, 100->1, 101->1, 110->0, 111->0.
- Equivalent minimal forms: ~b & (a | ~c).
- y is purely combinational and has zero latency.
  - y is independent of clk and rst_n, and valid even while reset is asserted.
  - y has no glitch requirement beyond standard combinational settling.
- Lanes are fully independent; there is no cross-lane interaction.
- y_q:
  - On each rising clk edge with rst_n=1, y_q <= y (one-cycle latency).
  - On a rising edge with rst_n=0, y_q <= '0.
- y_q_valid:
  - Reset value 0.
  - Set to 1 on the first rising edge with rst_n=1; stays 1 until the next reset.
- Reset mid-operation: the next rising edge with rst_n=0 clears y_q to 0 and y_q_valid to 0. The following edge with rst_n=1 reloads y_q from the current inputs and sets y_q_valid=1.
- Inputs changing between edges affect y immediately and y_q only at the next edge.
- No X propagation beyond standard semantics. Behaviour for X/Z inputs is undefined.

Decomposition:
- No shared package is required; the function is fully defined by the expression above.
- Optional sub-module silly_function_lane: a 1-bit combinational lane, instantiated WIDTH times via generate.
- The register stage stays in the top module.

Test Plan:
- Exhaustive sweep, WIDTH=1: hold each abc for 10 cycles, in order 000,001,010,011,100,101,110,111. Required y = 1,0,0,0,1,1,0,0. Required y_q equals the same sequence delayed one cycle.
- Reset behaviour:
  - Hold rst_n=0 for 3 edges with abc=100: y=1 throughout, y_q=0, y_q_valid=0.
  - Release rst_n: after the first edge, y_q=1 and y_q_valid=1.
- Reset mid-stream: with abc=101 and y_q=1, assert rst_n=0 for 1 edge. Required y_q=0 and y_q_valid=0; y stays 1. After release and one edge, y_q=1 and y_q_valid=1.
- Multi-lane, WIDTH=8: a=8'hF0, b=8'hCC, c=8'hAA. Required y=8'h31, with y_q=8'h31 one edge later.
- Combinational timing: change abc 000->010 mid-cycle. Required y falls 1->0 immediately; y_q updates only at the next rising edge.
- Random regression, WIDTH=8: 1000 random a/b/c vectors, checked against the reference model ~b & (a | ~c) on both y and the one-cycle-delayed y_q.
